// File: rtl/fp_pkg.sv
// Shared float/int conversion constants, operand class and stage payloads.
// Also used by the int-to-float normalisation path.
package fp_pkg;

   localparam int FP_BIAS   = 127;
   localparam int FP_EXP_W  = 8;
   localparam int FP_FRAC_W = 23;
   localparam logic [FP_EXP_W-1:0] FP_EXP_SPECIAL = 8'hFF;

   localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
   localparam logic [31:0] INT_MIN = 32'h80000000;

   // Exact float image of -2^31, the only out-of-range-looking value that fits.
   localparam logic [31:0] FP_NEG_2P31 = 32'hCF000000;

   localparam int STAGES = 3;

   typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

   typedef struct packed {
      logic                      sign;
      fp_class_e                 cls;
      logic                      is_min;
      logic [FP_EXP_W:0]         unb;
      logic [FP_FRAC_W:0]        m;
   } s1_t;

   typedef struct packed {
      logic                      sign;
      fp_class_e                 cls;
      logic                      sat;
      logic [32:0]               mag;
      logic                      guard;
      logic                      sticky;
      logic                      nz;
   } s2_t;

   function automatic fp_class_e fp_classify(input logic [FP_EXP_W-1:0] e,
                                             input logic [FP_FRAC_W-1:0] f);
      if (e == '0)
         return FP_ZERO;
      else if (e == FP_EXP_SPECIAL)
         return (f != '0) ? FP_NAN : FP_INF;
      else
         return FP_NORM;
   endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Denormalising barrel shifter: signed shift amount, positive shifts left,
// negative shifts right and reports the first dropped bit and the OR of the rest.
module fp_align_shift
   import fp_pkg::*;
(
   input  logic [FP_FRAC_W:0] m,
   input  logic signed [8:0]  sh,
   output logic [32:0]        mag,
   output logic               guard,
   output logic               sticky
);

   logic        neg;
   logic [8:0]  abs_sh;
   logic [4:0]  amt;
   logic [55:0] rwide;

   always_comb begin
      neg    = sh[8];
      abs_sh = neg ? 9'(-sh) : 9'(sh);
      amt    = (abs_sh > 9'd31) ? 5'd31 : abs_sh[4:0];
      // 32 zero bits below the mantissa catch everything a right shift drops.
      rwide  = {m, 32'd0} >> amt;
      mag    = neg ? {9'd0, rwide[55:32]} : ({9'd0, m} << amt);
      guard  = neg & rwide[31];
      sticky = neg & (|rwide[30:0]);
   end

endmodule

// File: rtl/fp_to_int.sv
// Pipelined single-precision float to signed 32-bit integer converter with a
// start/done, clk_en-gated handshake; fixed three-cycle latency after capture.
module fp_to_int
   import fp_pkg::*;
#(
   parameter int          ROUND_MODE = 0,
   parameter logic [31:0] NAN_VALUE  = 32'h80000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic        done,
   output logic [31:0] result,
   output logic        overflow,
   output logic        inexact
);

   logic [STAGES:0] vld_pipe;
   logic [31:0]     in_q;
   s1_t             s1_d, s1_q;
   s2_t             s2_d, s2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         in_q     <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
      end else if (clk_en) begin
         vld_pipe <= {vld_pipe[STAGES-1:0], start};
         in_q     <= dataa;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
      end
   end

   assign done = vld_pipe[STAGES];

   // Stage 1: unpack and classify
   always_comb begin
      s1_d        = '0;
      s1_d.sign   = in_q[31];
      s1_d.cls    = fp_classify(in_q[30:23], in_q[22:0]);
      s1_d.m      = {(in_q[30:23] != '0), in_q[22:0]};
      s1_d.unb    = 9'(in_q[30:23]) - 9'(FP_BIAS);
      s1_d.is_min = (in_q == FP_NEG_2P31);
   end

   // Stage 2: align by exponent
   logic signed [8:0] unb, sh;
   logic [32:0]       al_mag;
   logic              al_guard, al_sticky;

   assign unb = $signed(s1_q.unb);
   assign sh  = unb - 9'sd23;

   fp_align_shift u_align (
      .m      (s1_q.m),
      .sh     (sh),
      .mag    (al_mag),
      .guard  (al_guard),
      .sticky (al_sticky)
   );

   always_comb begin
      s2_d        = '0;
      s2_d.sign   = s1_q.sign;
      s2_d.cls    = s1_q.cls;
      s2_d.sat    = (s1_q.cls == FP_NORM) && (unb >= 9'sd31) && !s1_q.is_min;
      s2_d.mag    = al_mag;
      s2_d.guard  = al_guard;
      s2_d.sticky = al_sticky;
      s2_d.nz     = |s1_q.m;
   end

   // Stage 3: round, apply sign, saturate
   logic        inc;
   logic [32:0] mag_r;
   logic [31:0] sval, sat_res, res_d;
   logic        ovf_d, inx_d;

   always_comb begin
      inc     = (ROUND_MODE == 1) && s2_q.guard && (s2_q.sticky || s2_q.mag[0]);
      mag_r   = s2_q.mag + 33'(inc);
      sval    = s2_q.sign ? (~mag_r[31:0] + 32'd1) : mag_r[31:0];
      sat_res = s2_q.sign ? INT_MIN : INT_MAX;
      res_d   = '0;
      ovf_d   = 1'b0;
      inx_d   = 1'b0;
      case (s2_q.cls)
         FP_NAN: begin
            res_d = NAN_VALUE;
            ovf_d = 1'b1;
         end
         FP_INF: begin
            res_d = sat_res;
            ovf_d = 1'b1;
         end
         FP_ZERO: inx_d = s2_q.nz;
         default: begin
            if (s2_q.sat || mag_r[32]) begin
               res_d = sat_res;
               ovf_d = 1'b1;
            end else begin
               res_d = sval;
               inx_d = s2_q.guard | s2_q.sticky;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result   <= '0;
         overflow <= 1'b0;
         inexact  <= 1'b0;
      end else if (clk_en && vld_pipe[STAGES-1]) begin
         result   <= res_d;
         overflow <= ovf_d;
         inexact  <= inx_d;
      end
   end

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: truncating and round-to-nearest instances
// share stimulus; a monitor pops expected results whenever done is presented.
module tb_fp_to_int;

   logic        clk = 1'b0, reset_n = 1'b0, clk_en = 1'b0, start = 1'b0;
   logic [31:0] dataa = '0;
   logic        done0, ovf0, inx0, done1, ovf1, inx1;
   logic [31:0] res0, res1;

   always #5 clk = ~clk;

   fp_to_int #(.ROUND_MODE(0), .NAN_VALUE(32'h80000000)) u_rtz (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .dataa(dataa),
      .done(done0), .result(res0), .overflow(ovf0), .inexact(inx0));

   fp_to_int #(.ROUND_MODE(1), .NAN_VALUE(32'h80000000)) u_rne (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .dataa(dataa),
      .done(done1), .result(res1), .overflow(ovf1), .inexact(inx1));

   typedef struct {
      logic [31:0] a;
      logic [31:0] r0;
      logic [31:0] r1;
      logic        o;
      logic        i;
   } exp_t;

   exp_t q[$];
   exp_t last;
   bit   have_last = 1'b0;
   int   checks = 0, errors = 0;
   logic [3:0] mv;
   logic en_last = 1'b0;

   // Expected done timing: start seen on an enabled edge appears 3 enabled edges later.
   always @(posedge clk or negedge reset_n)
      if (!reset_n)    mv <= '0;
      else if (clk_en) mv <= {mv[2:0], start};

   always @(posedge clk) en_last <= clk_en;

   task automatic cmp(input string nm, input logic [31:0] a,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (dataa=%h): got %h, required %h", nm, a, act, exp);
      end
   endtask

   task automatic chk_out(input exp_t e);
      cmp("result_rtz",   e.a, res0,        e.r0);
      cmp("result_rne",   e.a, res1,        e.r1);
      cmp("overflow_rtz", e.a, 32'(ovf0),   32'(e.o));
      cmp("overflow_rne", e.a, 32'(ovf1),   32'(e.o));
      cmp("inexact_rtz",  e.a, 32'(inx0),   32'(e.i));
      cmp("inexact_rne",  e.a, 32'(inx1),   32'(e.i));
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         cmp("done_rtz", dataa, 32'(done0), 32'(mv[3]));
         cmp("done_rne", dataa, 32'(done1), 32'(mv[3]));
         if (done0 && en_last) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got result %h, required no output", res0);
            end else begin
               last      = q.pop_front();
               have_last = 1'b1;
               chk_out(last);
            end
         end else if (done0 && have_last) begin
            chk_out(last);   // clk_en low: outputs must still show the last result
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] r0,
                        input logic [31:0] r1, input logic o, input logic i);
      start  = 1'b1;
      dataa  = a;
      clk_en = 1'b1;
      q.push_back('{a, r0, r1, o, i});
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic idle(input int n, input logic en);
      repeat (n) begin
         start  = 1'b0;
         clk_en = en;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      cmp("reset_done",     0, 32'(done0 | done1), 0);
      cmp("reset_result",   0, res0 | res1,        0);
      cmp("reset_overflow", 0, 32'(ovf0 | ovf1),   0);
      cmp("reset_inexact",  0, 32'(inx0 | inx1),   0);
      reset_n = 1'b1;
      idle(2, 1'b1);

      // latency: single operand, then quiet
      issue(32'h3F800000, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
      idle(5, 1'b1);

      // rounding
      issue(32'hC0200000, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b1);
      issue(32'h40600000, 32'h00000003, 32'h00000004, 1'b0, 1'b1);
      issue(32'h40200000, 32'h00000002, 32'h00000002, 1'b0, 1'b1);
      issue(32'h3FC00000, 32'h00000001, 32'h00000002, 1'b0, 1'b1);
      issue(32'hBF400000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1);
      issue(32'h3F7FFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b1);
      issue(32'h3F000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
      // range boundaries and specials
      issue(32'h4F000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0);
      issue(32'hCF000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
      issue(32'hCF000001, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
      issue(32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0, 1'b0);
      issue(32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0);
      issue(32'hFF800000, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
      issue(32'h7FC00000, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
      issue(32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
      issue(32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
      idle(5, 1'b1);

      // back-to-back with a two-cycle stall after the second start
      issue(32'h3F800000, 32'd1, 32'd1, 1'b0, 1'b0);
      issue(32'h40000000, 32'd2, 32'd2, 1'b0, 1'b0);
      idle(2, 1'b0);
      issue(32'h40400000, 32'd3, 32'd3, 1'b0, 1'b0);
      issue(32'h40800000, 32'd4, 32'd4, 1'b0, 1'b0);
      idle(5, 1'b1);

      // stall while done is high; a start during the stall must be ignored
      issue(32'h42F60000, 32'd123, 32'd123, 1'b0, 1'b0);
      idle(3, 1'b1);
      start  = 1'b1;
      dataa  = 32'h40A00000;
      clk_en = 1'b0;
      @(posedge clk); #1;
      idle(1, 1'b0);
      idle(5, 1'b1);

      // reset one cycle after a start discards it
      issue(32'h42F60000, 32'd123, 32'd123, 1'b0, 1'b0);
      reset_n = 1'b0;
      q.delete();
      have_last = 1'b0;
      #1;
      cmp("midreset_done",   0, 32'(done0 | done1), 0);
      cmp("midreset_result", 0, res0 | res1,        0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(6, 1'b1);
      cmp("postreset_result", 0, res0 | res1, 0);
      cmp("postreset_flags",  0, 32'(ovf0 | ovf1 | inx0 | inx1), 0);

      // recovery after reset
      issue(32'h40400000, 32'd3, 32'd3, 1'b0, 1'b0);
      idle(6, 1'b1);
      cmp("scoreboard_drained", 0, q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
